// File: rtl/dual_lane_stall_pipeline.sv
// Two DEPTH-stage add lanes with a shared stall/flush; results appear DEPTH cycles after acceptance.
// Backpressure: stall freezes every stage and masks valid, so a held result is delivered once after the stall.
module dual_lane_stall_pipeline #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int STEP1 = 1,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            flush,
  input  logic [DW-1:0]   in_data_1,
  input  logic [DW-1:0]   in_data_2,
  input  logic [1:0]      in_valid,
  output logic            in_ready,
  output logic [DW-1:0]   pipeline1_outputs,
  output logic [DW-1:0]   pipeline2_outputs,
  output logic [1:0]      valid,
  output logic            busy,
  output logic [3:0]      occupancy_1,
  output logic [3:0]      occupancy_2,
  output logic [CNTW-1:0] stall_cycles
);

  logic [DEPTH-1:0][DW-1:0] d1_q, d1_n, d2_q, d2_n;
  logic [DEPTH-1:0]         v1_q, v1_n, v2_q, v2_n;
  logic                     advance;

  function automatic logic [3:0] popcnt(input logic [DEPTH-1:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + {3'b000, v[i]};
    return cnt;
  endfunction

  assign advance = ~stall & ~flush;
  assign in_ready = advance;

  // Data shifts regardless of valid; bubbles ride along as v=0.
  always_comb begin
    d1_n = d1_q;
    d2_n = d2_q;
    v1_n = v1_q;
    v2_n = v2_q;
    if (flush) begin
      v1_n = '0;
      v2_n = '0;
    end else if (!stall) begin
      v1_n    = {v1_q[DEPTH-2:0], in_valid[0]};
      v2_n    = {v2_q[DEPTH-2:0], in_valid[1]};
      d1_n[0] = in_data_1 + DW'(STEP1);
      d2_n[0] = in_data_2 + DW'(1);
      for (int i = 1; i < DEPTH; i++) begin
        d1_n[i] = d1_q[i-1] + DW'(STEP1);
        d2_n[i] = d2_q[i-1] + DW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d1_q         <= '0;
      d2_q         <= '0;
      v1_q         <= '0;
      v2_q         <= '0;
      occupancy_1  <= '0;
      occupancy_2  <= '0;
      stall_cycles <= '0;
    end else begin
      d1_q        <= d1_n;
      d2_q        <= d2_n;
      v1_q        <= v1_n;
      v2_q        <= v2_n;
      occupancy_1 <= popcnt(v1_n);
      occupancy_2 <= popcnt(v2_n);
      if (stall && busy && !flush && stall_cycles != {CNTW{1'b1}})
        stall_cycles <= stall_cycles + CNTW'(1);
    end
  end

  assign pipeline1_outputs = d1_q[DEPTH-1];
  assign pipeline2_outputs = d2_q[DEPTH-1];
  assign valid             = {v2_q[DEPTH-1], v1_q[DEPTH-1]} & {2{advance}};
  assign busy              = |v1_q | |v2_q;

endmodule
